wb_sram_slave: RTL and testbench
================================

WB_SRAM_SLAVE -- requirements
Module: wb_sram_slave

Interface
REQ-001: Parameter BASE_ADDR, default 32'h00000000, byte address of word 0.
REQ-002: Parameter DEPTH_WORDS, default 1024, number of 32-bit storage words, power of two, at least 2.
REQ-003: Parameter WAIT_STATES, default 1, extra cycles between request accept and response, 0..15.
REQ-004: clk input 1, sole clock; all logic rising-edge.
REQ-005: rst input 1, reset; one clock; reset is synchronous and active-high.
REQ-006: CYC input 1, bus cycle in progress.
REQ-007: STB input 1, request strobe.
REQ-008: WE input 1, 1 = write, 0 = read.
REQ-009: ADR input 32, byte address.
REQ-010: DAT_I input 32, write data.
REQ-011: SEL input 4, byte-lane enables; SEL[n] covers DAT bits 8n+7:8n.
REQ-012: DAT_O output 32, read data.
REQ-013: ACK output 1, successful completion, one-cycle pulse.
REQ-014: ERR output 1, error completion, one-cycle pulse.
REQ-015: STALL output 1, request not accepted this cycle.

Function
REQ-016: The FSM SHALL have the states IDLE, WAIT and RESP.
REQ-017: In IDLE, STALL = 0; CYC & STB high at a rising edge accepts the request and registers ADR, DAT_I, SEL and WE.
REQ-018: On accept, the FSM SHALL go to WAIT with counter = WAIT_STATES, or directly to RESP when WAIT_STATES = 0.
REQ-019: WAIT SHALL decrement the counter each cycle and go to RESP when the counter reaches 1.
REQ-020: Response latency SHALL be exactly WAIT_STATES+1 cycles: accept at edge N, ACK/ERR high during cycle N+WAIT_STATES+1.
REQ-021: STALL SHALL be 1 in WAIT and RESP.
REQ-022: RESP SHALL last one cycle, assert exactly one of ACK/ERR, then return to IDLE.
REQ-023: The next request is accepted no earlier than the edge that ends RESP; back-to-back throughput SHALL be one transfer per WAIT_STATES+2 cycles.
REQ-024: Decode: offset = latched ADR - BASE_ADDR, word index = offset[31:2], 32-bit unsigned arithmetic.
REQ-025: Error condition: ADR < BASE_ADDR, ADR >= BASE_ADDR + 4*DEPTH_WORDS (upper bound exclusive), or ADR[1:0] != 0.
REQ-026: An error condition SHALL produce ERR instead of ACK, with no memory write and DAT_O = 0.
REQ-027: A valid write SHALL update only the bytes with latched SEL bit set, committed at the edge ending RESP.
REQ-028: SEL = 0 on a write SHALL still produce ACK and leave memory unchanged.
REQ-029: A valid read SHALL drive the full addressed word on DAT_O during the RESP cycle, ignoring SEL.
REQ-030: DAT_O SHALL be 0 whenever ACK is 0.
REQ-031: ACK and ERR SHALL never be high simultaneously and SHALL be 0 outside RESP.
REQ-032: CYC low during WAIT or RESP SHALL abort the transfer: next state IDLE, no ACK/ERR, no write.
REQ-033: STB low after accept SHALL NOT affect the transfer.
REQ-034: Inputs other than CYC SHALL be ignored after accept; latched values govern the transfer.
REQ-035: A write followed by a read of the same word SHALL return the new data.

Reset
REQ-036: rst high at an edge SHALL set state = IDLE, counter = 0, ACK = 0, ERR = 0, STALL = 0 and DAT_O = 0.
REQ-037: Reset SHALL take priority over any transfer; reset mid-transfer aborts it with no write and no response.
REQ-038: Memory contents SHALL NOT be cleared by reset.

Verification
REQ-039: WAIT_STATES=1: write 0xDEADBEEF, SEL=4'hF, ADR=BASE+0x10 -> ACK 2 cycles after accept; read of same address -> DAT_O=0xDEADBEEF with ACK.
REQ-040: Partial write SEL=4'b0010, DAT_I=0x0000AB00 over 0xDEADBEEF -> read returns 0xDEADABEF.
REQ-041: Read at BASE+4*DEPTH_WORDS, then ADR=BASE+0x2 -> ERR pulse each, ACK=0, DAT_O=0, memory unchanged.
REQ-042: WAIT_STATES=3: CYC dropped one cycle after accept of a write -> no ACK/ERR, STALL=0 next cycle, later read shows old data.
REQ-043: rst asserted in WAIT of a write -> outputs at reset values next cycle, no response, target word unchanged, memory elsewhere retained.
REQ-044: WAIT_STATES=0: CYC/STB held high for 10 reads -> ACK every second cycle, STALL toggling 0/1, 5 completions.

Source files
------------

// File: rtl/wb_sram_slave.sv
// Wishbone pipelined-style SRAM slave: one outstanding request, fixed wait states,
// address-range/alignment error reporting and byte-lane writes.
module wb_sram_slave #(
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned WAIT_STATES = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        CYC,
    input  logic        STB,
    input  logic        WE,
    input  logic [31:0] ADR,
    input  logic [31:0] DAT_I,
    input  logic [3:0]  SEL,
    output logic [31:0] DAT_O,
    output logic        ACK,
    output logic        ERR,
    output logic        STALL
);

    localparam int unsigned AW   = $clog2(DEPTH_WORDS);
    localparam logic [32:0] SPAN = 33'(DEPTH_WORDS) << 2;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        we_q, we_d;
    logic [31:0] adr_q, adr_d;
    logic [31:0] dat_q, dat_d;
    logic [3:0]  sel_q, sel_d;

    logic [31:0] mem_q [DEPTH_WORDS];

    logic [31:0]   offset;
    logic          addr_err;
    logic [AW-1:0] idx;
    logic          resp_live;
    logic          wr_en;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        we_d    = we_q;
        adr_d   = adr_q;
        dat_d   = dat_q;
        sel_d   = sel_q;
        wr_en   = 1'b0;

        // Offset is compared as 33 bits so a base near the top of the map cannot wrap.
        offset    = adr_q - BASE_ADDR;
        addr_err  = (adr_q < BASE_ADDR) || ({1'b0, offset} >= SPAN) || (adr_q[1:0] != 2'b00);
        idx       = offset[AW+1:2];

        STALL     = (state_q != IDLE);
        resp_live = (state_q == RESP) && CYC && !rst;
        ACK       = resp_live && !addr_err;
        ERR       = resp_live && addr_err;
        DAT_O     = (ACK && !we_q) ? mem_q[idx] : '0;

        case (state_q)
            IDLE: begin
                if (CYC && STB) begin
                    we_d  = WE;
                    adr_d = ADR;
                    dat_d = DAT_I;
                    sel_d = SEL;
                    if (WAIT_STATES == 0) begin
                        state_d = RESP;
                        cnt_d   = '0;
                    end else begin
                        state_d = WAIT;
                        cnt_d   = 4'(WAIT_STATES);
                    end
                end
            end
            WAIT: begin
                if (!CYC) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                    if (cnt_q == 4'd1) state_d = RESP;
                end
            end
            RESP: begin
                state_d = IDLE;
                cnt_d   = '0;
                wr_en   = resp_live && we_q && !addr_err;
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            adr_q   <= '0;
            dat_q   <= '0;
            sel_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            adr_q   <= adr_d;
            dat_q   <= dat_d;
            sel_q   <= sel_d;
        end
    end

    // Storage is deliberately outside the reset domain; contents survive rst.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int unsigned b = 0; b < 4; b++) begin
                if (sel_q[b]) mem_q[idx][8*b +: 8] <= dat_q[8*b +: 8];
            end
        end
    end

endmodule

// File: tb/tb_wb_sram_slave.sv
// Self-checking bench for wb_sram_slave: three instances (1, 3 and 0 wait states)
// compared every cycle against a transaction-level model, plus literal spot checks.
module tb_wb_sram_slave;

    localparam int unsigned W0 = 1, W1 = 3, W2 = 0;
    localparam logic [31:0] B0 = 32'h0000_1000, B1 = 32'h0000_0000, B2 = 32'h8000_0000;
    localparam int unsigned D0 = 16, D1 = 8, D2 = 32;
    localparam int unsigned WS [3] = '{W0, W1, W2};
    localparam logic [31:0] BS [3] = '{B0, B1, B2};
    localparam int unsigned DS [3] = '{D0, D1, D2};

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst [3];
    logic        cyc [3];
    logic        stb [3];
    logic        we  [3];
    logic [31:0] adr [3];
    logic [31:0] dati[3];
    logic [3:0]  sel [3];
    logic [31:0] dato[3];
    logic        ack [3];
    logic        err [3];
    logic        stall[3];

    wb_sram_slave #(.BASE_ADDR(B0), .DEPTH_WORDS(D0), .WAIT_STATES(W0)) u0 (
        .clk(clk), .rst(rst[0]), .CYC(cyc[0]), .STB(stb[0]), .WE(we[0]), .ADR(adr[0]),
        .DAT_I(dati[0]), .SEL(sel[0]), .DAT_O(dato[0]), .ACK(ack[0]), .ERR(err[0]), .STALL(stall[0]));
    wb_sram_slave #(.BASE_ADDR(B1), .DEPTH_WORDS(D1), .WAIT_STATES(W1)) u1 (
        .clk(clk), .rst(rst[1]), .CYC(cyc[1]), .STB(stb[1]), .WE(we[1]), .ADR(adr[1]),
        .DAT_I(dati[1]), .SEL(sel[1]), .DAT_O(dato[1]), .ACK(ack[1]), .ERR(err[1]), .STALL(stall[1]));
    wb_sram_slave #(.BASE_ADDR(B2), .DEPTH_WORDS(D2), .WAIT_STATES(W2)) u2 (
        .clk(clk), .rst(rst[2]), .CYC(cyc[2]), .STB(stb[2]), .WE(we[2]), .ADR(adr[2]),
        .DAT_I(dati[2]), .SEL(sel[2]), .DAT_O(dato[2]), .ACK(ack[2]), .ERR(err[2]), .STALL(stall[2]));

    int unsigned total = 0;
    int unsigned bad   = 0;
    bit          chk_en = 1'b0;
    int unsigned ecnt  = 0;

    // Transaction-level model: one pending request per instance, timed by edge numbers.
    bit          busy [3];
    int unsigned acc  [3];
    bit          mwe  [3];
    logic [31:0] madr [3];
    logic [31:0] mdat [3];
    logic [3:0]  msel [3];
    logic [31:0] mmem [3][32];
    bit          known[3][32];

    function automatic bit addr_ok(input int i, input logic [31:0] a);
        longint unsigned av, lo, hi;
        av = 64'(a);
        lo = 64'(BS[i]);
        hi = lo + 64'(4 * DS[i]);
        return (av >= lo) && (av < hi) && (a[1:0] == 2'b00);
    endfunction

    function automatic int unsigned widx(input int i, input logic [31:0] a);
        return 32'((a - BS[i]) >> 2);
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    initial begin
        for (int i = 0; i < 3; i++) busy[i] = 1'b0;
        forever begin
            @(posedge clk);
            ecnt++;
            for (int i = 0; i < 3; i++) begin
                if (rst[i]) begin
                    busy[i] = 1'b0;
                end else if (busy[i]) begin
                    if (!cyc[i]) begin
                        busy[i] = 1'b0;
                    end else if (ecnt == acc[i] + WS[i] + 1) begin
                        if (mwe[i] && addr_ok(i, madr[i])) begin
                            int unsigned w;
                            w = widx(i, madr[i]);
                            for (int b = 0; b < 4; b++)
                                if (msel[i][b]) mmem[i][w][8*b +: 8] = mdat[i][8*b +: 8];
                            if (msel[i] == 4'hF) known[i][w] = 1'b1;
                        end
                        busy[i] = 1'b0;
                    end
                end else if (cyc[i] && stb[i]) begin
                    busy[i] = 1'b1;
                    acc[i]  = ecnt;
                    mwe[i]  = we[i];
                    madr[i] = adr[i];
                    mdat[i] = dati[i];
                    msel[i] = sel[i];
                end
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (chk_en) begin
                for (int i = 0; i < 3; i++) begin
                    bit live, ok;
                    live = busy[i] && (ecnt == acc[i] + WS[i]) && cyc[i] && !rst[i];
                    ok   = addr_ok(i, madr[i]);
                    chk($sformatf("stall[%0d]", i), 32'(stall[i]), 32'(busy[i]));
                    chk($sformatf("ack[%0d]", i), 32'(ack[i]), 32'(live && ok));
                    chk($sformatf("err[%0d]", i), 32'(err[i]), 32'(live && !ok));
                    if (!(live && ok))
                        chk($sformatf("dat_idle[%0d]", i), dato[i], 32'd0);
                    else if (!mwe[i] && known[i][widx(i, madr[i])])
                        chk($sformatf("dat_rd[%0d]", i), dato[i], mmem[i][widx(i, madr[i])]);
                end
            end
        end
    end

    task automatic xfer(input int i, input bit w, input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] s, output logic [31:0] rd, output bit ga, output bit ge,
                        output int lat);
        cyc[i] = 1'b1; stb[i] = 1'b1; we[i] = w; adr[i] = a; dati[i] = d; sel[i] = s;
        @(posedge clk); #1;
        stb[i]  = 1'($urandom_range(0, 1));
        we[i]   = 1'($urandom);
        adr[i]  = $urandom;
        dati[i] = $urandom;
        sel[i]  = 4'($urandom);
        rd = '0; ga = 1'b0; ge = 1'b0; lat = 0;
        while (lat < 40 && !ga && !ge) begin
            @(negedge clk);
            lat++;
            ga = ack[i];
            ge = err[i];
            rd = dato[i];
        end
        total++;
        if (!(ga || ge)) begin
            bad++;
            $display("FAIL timeout[%0d]: got no response want ACK/ERR within 40 cycles", i);
        end
        @(posedge clk); #1;
        cyc[i] = 1'b0; stb[i] = 1'b0;
    endtask

    initial begin
        logic [31:0] rd;
        bit ga, ge;
        int lat, na;

        for (int i = 0; i < 3; i++) begin
            rst[i] = 1'b1; cyc[i] = 1'b0; stb[i] = 1'b0; we[i] = 1'b0;
            adr[i] = '0; dati[i] = '0; sel[i] = '0;
        end
        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) rst[i] = 1'b0;
        chk_en = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("rst_stall[%0d]", i), 32'(stall[i]), 32'd0);
            chk($sformatf("rst_ack[%0d]", i), 32'(ack[i]), 32'd0);
            chk($sformatf("rst_dat[%0d]", i), dato[i], 32'd0);
        end
        @(posedge clk); #1;

        for (int i = 0; i < 3; i++)
            for (int w = 0; w < int'(DS[i]); w++)
                xfer(i, 1'b1, BS[i] + 32'(4 * w), $urandom, 4'hF, rd, ga, ge, lat);

        // Full write then read, 1 wait state.
        xfer(0, 1'b1, B0 + 32'h10, 32'hDEADBEEF, 4'hF, rd, ga, ge, lat);
        chk("w_ack", 32'(ga), 32'd1);
        chk("w_lat", 32'(lat), 32'd2);
        xfer(0, 1'b0, B0 + 32'h10, 32'h0, 4'h0, rd, ga, ge, lat);
        chk("r_data", rd, 32'hDEADBEEF);
        chk("r_lat", 32'(lat), 32'd2);

        xfer(0, 1'b1, B0 + 32'h10, 32'h0000AB00, 4'b0010, rd, ga, ge, lat);
        xfer(0, 1'b0, B0 + 32'h10, 32'h0, 4'hF, rd, ga, ge, lat);
        chk("partial", rd, 32'hDEADABEF);
        xfer(0, 1'b1, B0 + 32'h10, 32'h12345678, 4'h0, rd, ga, ge, lat);
        chk("sel0_ack", 32'(ga), 32'd1);
        xfer(0, 1'b0, B0 + 32'h10, 32'h0, 4'hF, rd, ga, ge, lat);
        chk("sel0_keep", rd, 32'hDEADABEF);

        // Error completions: past the end, misaligned, below base.
        xfer(0, 1'b0, B0 + 32'(4 * D0), 32'h0, 4'hF, rd, ga, ge, lat);
        chk("oob_err", 32'(ge), 32'd1);
        chk("oob_ack", 32'(ga), 32'd0);
        chk("oob_dat", rd, 32'd0);
        xfer(0, 1'b0, B0 + 32'h2, 32'h0, 4'hF, rd, ga, ge, lat);
        chk("mis_err", 32'(ge), 32'd1);
        chk("mis_dat", rd, 32'd0);
        xfer(0, 1'b1, B0 + 32'h2, 32'hFFFFFFFF, 4'hF, rd, ga, ge, lat);
        chk("mis_w_err", 32'(ge), 32'd1);
        xfer(0, 1'b1, B0 - 32'h4, 32'hFFFFFFFF, 4'hF, rd, ga, ge, lat);
        chk("low_err", 32'(ge), 32'd1);
        xfer(0, 1'b0, B0, 32'h0, 4'hF, rd, ga, ge, lat);
        chk("err_nowrite", rd, mmem[0][0]);

        // Abort by dropping CYC one cycle after accept, 3 wait states.
        xfer(1, 1'b1, 32'h8, 32'h0BADF00D, 4'hF, rd, ga, ge, lat);
        chk("w3_lat", 32'(lat), 32'd4);
        cyc[1] = 1'b1; stb[1] = 1'b1; we[1] = 1'b1; adr[1] = 32'h8; dati[1] = 32'h11111111; sel[1] = 4'hF;
        @(posedge clk); #1;
        stb[1] = 1'b0;
        @(posedge clk); #1;
        cyc[1] = 1'b0;
        @(negedge clk);
        chk("abort_ack", 32'(ack[1] | err[1]), 32'd0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("abort_stall", 32'(stall[1]), 32'd0);
        @(posedge clk); #1;
        xfer(1, 1'b0, 32'h8, 32'h0, 4'hF, rd, ga, ge, lat);
        chk("abort_old", rd, 32'h0BADF00D);

        // Reset during the wait state of a write.
        xfer(0, 1'b1, B0 + 32'h8, 32'hCAFEF00D, 4'hF, rd, ga, ge, lat);
        cyc[0] = 1'b1; stb[0] = 1'b1; we[0] = 1'b1; adr[0] = B0 + 32'h8; dati[0] = 32'h55555555; sel[0] = 4'hF;
        @(posedge clk); #1;
        rst[0] = 1'b1; stb[0] = 1'b0;
        @(posedge clk); #1;
        rst[0] = 1'b0; cyc[0] = 1'b0;
        @(negedge clk);
        chk("rstw_stall", 32'(stall[0]), 32'd0);
        chk("rstw_resp", 32'(ack[0] | err[0]), 32'd0);
        chk("rstw_dat", dato[0], 32'd0);
        @(posedge clk); #1;
        xfer(0, 1'b0, B0 + 32'h8, 32'h0, 4'hF, rd, ga, ge, lat);
        chk("rstw_target", rd, 32'hCAFEF00D);
        xfer(0, 1'b0, B0 + 32'h10, 32'h0, 4'hF, rd, ga, ge, lat);
        chk("rstw_retain", rd, 32'hDEADABEF);

        // Zero wait states: single latency, errors, then back-to-back reads.
        xfer(2, 1'b0, B2 + 32'h4, 32'h0, 4'hF, rd, ga, ge, lat);
        chk("w0_lat", 32'(lat), 32'd1);
        xfer(2, 1'b0, B2 - 32'h4, 32'h0, 4'hF, rd, ga, ge, lat);
        chk("w0_low_err", 32'(ge), 32'd1);
        xfer(2, 1'b0, B2 + 32'(4 * D2), 32'h0, 4'hF, rd, ga, ge, lat);
        chk("w0_top_err", 32'(ge), 32'd1);
        cyc[2] = 1'b1; stb[2] = 1'b1; we[2] = 1'b0; sel[2] = 4'hF;
        adr[2] = B2 + 32'(4 * $urandom_range(0, D2 - 1));
        na = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (ack[2]) na++;
            chk($sformatf("b2b_stall%0d", k), 32'(stall[2]), 32'(k % 2));
            @(posedge clk); #1;
            adr[2] = B2 + 32'(4 * $urandom_range(0, D2 - 1));
        end
        cyc[2] = 1'b0; stb[2] = 1'b0;
        chk("b2b_count", 32'(na), 32'd5);

        // Randomized traffic on all instances.
        for (int i = 0; i < 3; i++) begin
            for (int n = 0; n < 40; n++) begin
                logic [31:0] a;
                if ($urandom_range(0, 9) < 8) a = BS[i] + 32'(4 * $urandom_range(0, DS[i] - 1));
                else if ($urandom_range(0, 1) == 0) a = BS[i] + 32'(4 * DS[i]) + 32'($urandom_range(0, 7));
                else a = $urandom;
                xfer(i, 1'($urandom), a, $urandom, 4'($urandom), rd, ga, ge, lat);
                repeat ($urandom_range(0, 2)) @(posedge clk);
                #1;
            end
        end

        repeat (3) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
